// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-RAM program loader.
package loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/byte_to_word.sv
// Assembles accepted bytes into little-endian 32-bit words.
module byte_to_word
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [IDX_W-1:0] idx_q;
  logic [23:0]      asm_q;
  logic             last_byte;

  assign last_byte  = (idx_q == IDX_W'(WORD_BYTES - 1));
  // The 4th byte bypasses the register so the word is usable in its accept cycle.
  assign word_valid = accept && last_byte;
  assign word       = {in_data, asm_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (accept) begin
      idx_q <= idx_q + 1'b1;
      unique case (idx_q)
        2'd0:    asm_q[7:0]   <= in_data;
        2'd1:    asm_q[15:8]  <= in_data;
        2'd2:    asm_q[23:16] <= in_data;
        default: asm_q        <= asm_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_ram_loader.sv
// Loads a length-prefixed, XOR-checksummed word stream into instruction RAM.
module inst_ram_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        debug,
  output logic        inst_ram_write_enable,
  output logic [31:0] inst_ram_write_data,
  output logic [31:0] inst_ram_write_address,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [15:0]      len_q;
  logic [15:0]      wl_q;
  logic [31:0]      csum_q;
  logic [TMO_W-1:0] tmo_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [31:0]      waddr_q;

  logic        busy;
  logic        accept;
  logic        start_load;
  logic        tmo_hit;
  logic        len_ok;
  logic        last_word;
  logic [31:0] word;
  logic        word_valid;

  assign busy       = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  // The strobe cycle blocks input so a new word can never overlap a pending write.
  assign in_ready   = busy && !we_q;
  assign accept     = in_valid && in_ready;
  assign start_load = start && !busy;
  assign tmo_hit    = busy && !accept && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign len_ok     = (word != 32'd0) && (word <= 32'(MAX_WORDS));
  assign last_word  = (wl_q == len_q - 16'd1);

  byte_to_word u_byte_to_word (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_load),
    .accept     (accept),
    .in_data    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLen;
      end
      StLen: begin
        if (tmo_hit)         state_d = StErr;
        else if (word_valid) state_d = len_ok ? StData : StErr;
      end
      StData: begin
        if (tmo_hit)                      state_d = StErr;
        else if (word_valid && last_word) state_d = StCsum;
      end
      StCsum: begin
        if (tmo_hit)         state_d = StErr;
        else if (word_valid) state_d = (word == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      wl_q    <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;

      if (start_load) begin
        wl_q   <= '0;
        csum_q <= '0;
      end

      if (state_q == StLen && word_valid && len_ok) begin
        len_q <= word[15:0];
      end

      if (state_q == StData && word_valid) begin
        we_q    <= 1'b1;
        wdata_q <= word;
        waddr_q <= BASE_ADDR + (32'(wl_q) << 2);
        wl_q    <= wl_q + 16'd1;
        csum_q  <= csum_q ^ word;
      end

      if (accept || (state_d != state_q) || !busy) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign debug                  = busy;
  assign inst_ram_write_enable  = we_q;
  assign inst_ram_write_data    = wdata_q;
  assign inst_ram_write_address = waddr_q;
  assign done                   = (state_q == StDone);
  assign error                  = (state_q == StErr);
  assign words_loaded           = wl_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Self-checking bench: transaction-level model of expected RAM writes and load outcome.
module tb_inst_ram_loader;

  localparam int unsigned MAXW = 8;
  localparam int unsigned TMO  = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        debug;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] waddr;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  inst_ram_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .in_valid               (in_valid),
    .in_data                (in_data),
    .in_ready               (in_ready),
    .debug                  (debug),
    .inst_ram_write_enable  (we),
    .inst_ram_write_data    (wdata),
    .inst_ram_write_address (waddr),
    .done                   (done),
    .error                  (error),
    .words_loaded           (words_loaded)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] seen_addr[$];
  logic [31:0] seen_data[$];
  logic [31:0] wbuf[0:15];
  logic        prev_we = 1'b0;
  bit          noise_start = 1'b0;
  int          long_gap_at = -1;
  int          byte_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Per-cycle rules, evaluated at every falling edge.
  task automatic monitor();
    check("in_ready_rule", {31'd0, in_ready}, {31'd0, debug && !we});
    check("done_error_excl", {31'd0, done && error}, 32'd0);
    if (we) begin
      check("strobe_debug", {31'd0, debug}, 32'd1);
      check("strobe_single", {31'd0, prev_we}, 32'd0);
      seen_addr.push_back(waddr);
      seen_data.push_back(wdata);
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: actual addr=%h data=%h required no strobe", waddr, wdata);
      end else begin
        check("strobe_addr", waddr, exp_addr.pop_front());
        check("strobe_data", wdata, exp_data.pop_front());
        check("strobe_count", {16'd0, words_loaded}, 32'(seen_addr.size()));
      end
    end
    prev_we = we;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_debug"}, {31'd0, debug}, 32'd0);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_waddr"}, waddr, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    if (noise_start) start = 1'($urandom_range(0, 1));
    #1;
    while (!in_ready && waited < 40) begin
      tick();
      waited++;
      #1;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_bound: in_ready actual=0 required=1 for byte %h", b);
    end else begin
      tick();
      byte_no++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      int g;
      g = (byte_no == long_gap_at) ? int'(TMO) - 1 : int'($urandom_range(0, max_gap));
      send_byte(w[8*k +: 8], g);
    end
  endtask

  function automatic logic [31:0] xor_words(input int n);
    logic [31:0] x = 32'd0;
    for (int i = 0; i < n; i++) x ^= wbuf[i];
    return x;
  endfunction

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    byte_no = 0;
    check("start_debug", {31'd0, debug}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_error", {31'd0, error}, 32'd0);
    check("start_words", {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic run_load(input logic [31:0] n, input logic [31:0] csum, input int max_gap);
    bit len_ok;
    bit good;
    len_ok = (n != 32'd0) && (n <= 32'(MAXW));
    seen_addr.delete();
    seen_data.delete();
    if (len_ok) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_addr.push_back(BASE + 32'(4 * i));
        exp_data.push_back(wbuf[i]);
      end
    end
    do_start();
    send_word(n, max_gap);
    if (!len_ok) begin
      check("len_err", {31'd0, error}, 32'd1);
      check("len_err_done", {31'd0, done}, 32'd0);
      check("len_err_debug", {31'd0, debug}, 32'd0);
      check("len_err_nostrobe", 32'(seen_addr.size()), 32'd0);
      return;
    end
    for (int i = 0; i < int'(n); i++) send_word(wbuf[i], max_gap);
    send_word(csum, max_gap);
    good = (csum == xor_words(int'(n)));
    check("end_done", {31'd0, done}, {31'd0, good});
    check("end_error", {31'd0, error}, {31'd0, !good});
    check("end_debug", {31'd0, debug}, 32'd0);
    check("end_words", {16'd0, words_loaded}, n);
    check("end_pending", 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] cs;
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Nominal load, then the same data with a bad checksum.
    wbuf[0] = 32'h2402_0005;
    wbuf[1] = 32'h0000_0000;
    run_load(32'd2, 32'h2402_0005, 0);
    check("nom_count", 32'(seen_addr.size()), 32'd2);
    check("nom_addr0", seen_addr[0], 32'h0000_0000);
    check("nom_addr1", seen_addr[1], 32'h0000_0004);
    check("nom_data0", seen_data[0], 32'h2402_0005);
    check("nom_data1", seen_data[1], 32'h0000_0000);
    check("nom_done", {31'd0, done}, 32'd1);

    run_load(32'd2, 32'h0000_0001, 0);
    check("bad_count", 32'(seen_addr.size()), 32'd2);
    check("bad_error", {31'd0, error}, 32'd1);
    check("bad_done", {31'd0, done}, 32'd0);

    // Length bounds.
    run_load(32'd0, 32'd0, 0);
    run_load(32'(MAXW + 1), 32'd0, 0);
    for (int i = 0; i < int'(MAXW); i++) wbuf[i] = $urandom;
    run_load(32'(MAXW), xor_words(int'(MAXW)), 0);
    check("max_last_addr", seen_addr[seen_addr.size() - 1], 32'h0000_001C);

    // Stalled nominal load, including one gap of exactly TIMEOUT-1 idle cycles.
    wbuf[0] = 32'h2402_0005;
    wbuf[1] = 32'h0000_0000;
    long_gap_at = 6;
    run_load(32'd2, 32'h2402_0005, 12);
    long_gap_at = -1;
    check("stall_done", {31'd0, done}, 32'd1);
    check("stall_data0", seen_data[0], 32'h2402_0005);
    check("stall_addr1", seen_addr[1], 32'h0000_0004);

    // Random loads with start toggling while busy.
    noise_start = 1'b1;
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, MAXW));
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      cs = xor_words(n);
      if ($urandom_range(0, 1) == 1) cs ^= (32'h1 << $urandom_range(0, 31));
      run_load(32'(n), cs, 10);
    end
    noise_start = 1'b0;

    // Timeout after the 2nd byte of data word 1.
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    seen_addr.delete();
    seen_data.delete();
    exp_addr.push_back(BASE);
    exp_data.push_back(wbuf[0]);
    do_start();
    send_word(32'd2, 0);
    send_word(wbuf[0], 0);
    send_byte(wbuf[1][7:0], 0);
    send_byte(wbuf[1][15:8], 0);
    repeat (TMO - 1) tick();
    check("tmo_early_error", {31'd0, error}, 32'd0);
    check("tmo_early_debug", {31'd0, debug}, 32'd1);
    tick();
    check("tmo_error", {31'd0, error}, 32'd1);
    check("tmo_done", {31'd0, done}, 32'd0);
    check("tmo_debug", {31'd0, debug}, 32'd0);
    check("tmo_words", {16'd0, words_loaded}, 32'd1);
    check("tmo_pending", 32'(exp_addr.size()), 32'd0);

    // Reset after 3 bytes of word 1.
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    seen_addr.delete();
    seen_data.delete();
    exp_addr.push_back(BASE);
    exp_data.push_back(wbuf[0]);
    do_start();
    send_word(32'd2, 0);
    send_word(wbuf[0], 0);
    for (int k = 0; k < 3; k++) send_byte(wbuf[1][8*k +: 8], 0);
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_strobes", 32'(seen_addr.size()), 32'd1);
    check("midrst_pending", 32'(exp_addr.size()), 32'd0);

    // A fresh load after reset must not see the discarded partial word.
    wbuf[0] = 32'h2402_0005;
    wbuf[1] = 32'h0000_0000;
    run_load(32'd2, 32'h2402_0005, 3);
    check("post_rst_done", {31'd0, done}, 32'd1);
    check("post_rst_data0", seen_data[0], 32'h2402_0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_ram_loader.md
# inst_ram_loader

Program loader that drives the CPU's instruction-RAM debug write port (`debug`, `inst_ram_write_enable`, `inst_ram_write_data`, `inst_ram_write_address`). It takes a byte stream from a serial receiver through a valid/ready handshake and assembles little-endian 32-bit words. It writes each word to consecutive word addresses and verifies an XOR checksum. It sits beside `CPU` at the top level, and `CPU` fetches normally only while this block's `debug` output is low.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first loaded word.
- `MAX_WORDS`, default 1024: largest accepted word count.
- `TIMEOUT`, default 1_000_000: idle cycles allowed between accepted bytes while busy.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a load; sampled in IDLE, DONE and ERR only.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  block accepts a byte this cycle.
- `debug`  out  1  high while loading; drives CPU `debug`.
- `inst_ram_write_enable`  out  1  one-cycle write strobe.
- `inst_ram_write_data`  out  32  word to write.
- `inst_ram_write_address`  out  32  byte address of the word.
- `done`  out  1  load completed with a good checksum.
- `error`  out  1  load aborted.
- `words_loaded`  out  16  count of words written in the current or last load.

## Operation
- States and behaviour:
  - IDLE: wait for `start`.
  - LEN: receive a 4-byte word count N.
  - DATA: receive N words.
  - CSUM: receive a 4-byte checksum word.
  - DONE and ERR: terminal until the next `start`.
- Byte accept: a byte is accepted when `in_valid && in_ready`. A 2-bit byte index assembles the word little-endian, so the first byte goes to bits [7:0].
- LEN: if N == 0 or N > MAX_WORDS, go to ERR. Otherwise go to DATA.
- DATA: on the 4th byte of a word:
  - register the word;
  - pulse `inst_ram_write_enable` for exactly one cycle on the next cycle;
  - present address `BASE_ADDR + 4*i`, where i is the word index from 0;
  - increment `words_loaded`;
  - XOR the word into the running checksum, which starts at 0.
- After word N-1 is accepted, go to CSUM.
- CSUM: if the received word equals the running XOR, go to DONE; otherwise go to ERR.
- Timeout: in LEN, DATA or CSUM, if TIMEOUT cycles pass with no accepted byte, go to ERR. The timeout counter clears on every accepted byte and on state entry.
- `start` in DONE or ERR:
  - clears `done`, `error`, `words_loaded`, the checksum and the byte index;
  - enters LEN.
- `start` while busy is ignored.
- Words already written before an ERR stay in RAM. No rollback is performed.

## Timing
- Reset values: every output 0, state IDLE, all counters 0.
- Reset mid-load: immediate return to IDLE with `debug` low. A partially assembled word is discarded and no strobe is issued.
- `in_ready` is 1 in LEN, DATA and CSUM, except in the strobe cycle that follows a word completion. In that cycle `in_ready` is 0, which gives a maximum rate of one word per 5 cycles.
- `debug` rises in the cycle LEN is entered. It stays high through the final strobe and falls on entry to DONE or ERR.
- `inst_ram_write_data` and `inst_ram_write_address` are valid in the strobe cycle and held until the next strobe.
- The last-word strobe completes before the first CSUM byte can be accepted.
- `done` and `error` are levels and are never high together.
- Latency from 4th byte accepted to strobe: 1 cycle.
- Latency from last checksum byte accepted to `done` or `error`: 1 cycle.
- Timeout boundary: ERR is entered on the cycle the counter reaches TIMEOUT−1 with no byte accepted.

## Structure
- Shared package `loader_pkg`, holding:
  - the state enum (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - the byte-index width constant;
  - the `WORD_BYTES` = 4 constant.
- One natural sub-module: `byte_to_word`.
  - It contains the 2-bit index, the shift/assemble register and a `word_valid` pulse.
  - The FSM, counters, checksum and timeout stay in `inst_ram_loader`.

## Test plan
- Nominal load:
  - Stimulus: `start`, then N=2, words 32'h2402_0005 and 32'h0000_0000, then checksum 32'h2402_0005, with bytes back to back.
  - Required: two strobes at addresses 0x0 and 0x4 with those data values, `words_loaded`=2, `done`=1, `debug` falling on DONE.
- Bad checksum:
  - Stimulus: same load with checksum 32'h0000_0001.
  - Required: both strobes still occur, `error`=1, `done`=0.
- Length bounds:
  - Stimulus: N=0; separately N=MAX_WORDS+1.
  - Required: ERR with no strobe in both cases.
  - Stimulus: N=MAX_WORDS.
  - Required: last address is `BASE_ADDR`+4*(MAX_WORDS−1).
- Handshake stalls and timeout:
  - Stimulus: random `in_valid` gaps shorter than TIMEOUT.
  - Required: data is identical to the nominal load.
  - Stimulus: a gap of TIMEOUT cycles after the 2nd byte of a data word, with TIMEOUT=16 for the bench.
  - Required: ERR, with `words_loaded` unchanged.
- Reset and restart:
  - Stimulus: assert reset after 3 bytes of word 1.
  - Required: all outputs 0 and no strobe.
  - Stimulus: after DONE, assert `start` and run a second load.
  - Required: `done` clears and `words_loaded` restarts from 0.
- Back-pressure:
  - Stimulus: a load with bytes back to back.
  - Required: `in_ready` is 0 exactly in each strobe cycle.
